aes_key_schedule: RTL and testbench

Word-serial AES key-schedule generator covering AES-128/192/256 (FIPS-197), selected per job at start. Accepts a key via start handshake and streams Nr+1 round keys (11/13/15) in round order over a valid/ready interface. Sits between key load and the round datapath, so round keys can feed a round pipeline with backpressure. Bytes are MSB-first: byte 0 of a word is bits [31:24].

---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_sub_word.sv | 31 +++
 rtl/aes_key_schedule.sv | 179 +++++++++++++++++
 tb/tb_aes_key_schedule.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, round constants and key-size helpers.
// Latency: none (types and pure functions); backpressure: n/a.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        AES128 = 2'd0,
        AES192 = 2'd1,
        AES256 = 2'd2
    } key_size_t;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [3:0] nk_of(key_size_t ks);
        case (ks)
            AES128:  return 4'd4;
            AES192:  return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(key_size_t ks);
        case (ks)
            AES128:  return 4'd10;
            AES192:  return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel AES S-boxes applied to one 32-bit word.
// Latency: combinational; backpressure: n/a.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t w,
    output word_t s
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};

endmodule

// File: rtl/aes_key_schedule.sv
// Word-serial AES-128/192/256 key expansion streaming Nr+1 round keys in order.
// Latency: first key 4 cycles after start, then one per 4 cycles; backpressure: rk_ready low stalls expansion.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_W = 256,
    parameter int RK_W  = 128
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    output logic             start_ready,
    input  logic [1:0]       key_size,
    input  logic [KEY_W-1:0] key_in,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_data,
    output logic [3:0]       rk_round,
    output logic             rk_last,
    output logic             done
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    logic [0:0]       state_q, state_d;
    key_size_t        ks_q, ks_d;
    logic [KEY_W-1:0] key_q, key_d;
    word_t            win_q [8];
    word_t            win_d [8];
    word_t            asm_q [3];
    word_t            asm_d [3];
    logic [2:0]       mod_q, mod_d;
    logic [3:0]       rcon_q, rcon_d;
    logic [5:0]       i_q, i_d;
    logic             rk_valid_q, rk_valid_d;
    logic [RK_W-1:0]  rk_data_q, rk_data_d;
    logic [3:0]       rk_round_q, rk_round_d;
    logic             rk_last_q, rk_last_d;
    logic             done_q, done_d;

    logic [3:0] nk, nr;
    logic [2:0] nkm1;
    logic [5:0] total;
    logic       hs, out_free, in_key, last_of_four, adv;
    word_t      sub_in, sub_out, t, w_new;

    assign nk    = nk_of(ks_q);
    assign nr    = nr_of(ks_q);
    assign nkm1  = 3'(nk - 4'd1);
    assign total = {nr + 4'd1, 2'b00};

    assign hs           = rk_valid_q && rk_ready;
    assign out_free     = !rk_valid_q || rk_ready;
    assign in_key       = ({2'b00, nk} > i_q);
    assign last_of_four = (i_q[1:0] == 2'd3);
    assign adv          = (state_q == ST_EXPAND) && (i_q < total) && (!last_of_four || out_free);

    // One shared S-box bank: RotWord only on the Rcon steps.
    assign sub_in = (mod_q == 3'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];

    aes_sub_word u_sub_word (
        .w (sub_in),
        .s (sub_out)
    );

    always_comb begin
        t = win_q[0];
        if (mod_q == 3'd0) begin
            t = sub_out ^ {RCON[rcon_q], 24'h0};
        end else if (nk == 4'd8 && mod_q == 3'd4) begin
            t = sub_out;
        end
        w_new = in_key ? key_q[KEY_W-1 -: 32] : (win_q[nkm1] ^ t);
    end

    always_comb begin
        state_d    = state_q;
        ks_d       = ks_q;
        key_d      = key_q;
        win_d      = win_q;
        asm_d      = asm_q;
        mod_d      = mod_q;
        rcon_d     = rcon_q;
        i_d        = i_q;
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_round_d = rk_round_q;
        rk_last_d  = rk_last_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && key_size != 2'd3) begin
                    state_d = ST_EXPAND;
                    ks_d    = key_size_t'(key_size);
                    key_d   = key_in;
                    win_d   = '{default: '0};
                    mod_d   = 3'd0;
                    rcon_d  = 4'd0;
                    i_d     = 6'd0;
                end
            end
            ST_EXPAND: begin
                if (hs) begin
                    rk_valid_d = 1'b0;
                    if (rk_last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                if (adv) begin
                    key_d = key_q << 32;
                    for (int k = 7; k > 0; k--) begin
                        win_d[k] = win_q[k-1];
                    end
                    win_d[0] = w_new;
                    mod_d    = (mod_q == nkm1) ? 3'd0 : mod_q + 3'd1;
                    if (mod_q == 3'd0 && !in_key && rcon_q != 4'd9) begin
                        rcon_d = rcon_q + 4'd1;
                    end
                    i_d = i_q + 6'd1;
                    case (i_q[1:0])
                        2'd0:    asm_d[0] = w_new;
                        2'd1:    asm_d[1] = w_new;
                        2'd2:    asm_d[2] = w_new;
                        default: begin
                            rk_valid_d = 1'b1;
                            rk_data_d  = {asm_q[0], asm_q[1], asm_q[2], w_new};
                            rk_round_d = i_q[5:2];
                            rk_last_d  = (i_q[5:2] == nr);
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ks_q       <= AES128;
            key_q      <= '0;
            win_q      <= '{default: '0};
            asm_q      <= '{default: '0};
            mod_q      <= 3'd0;
            rcon_q     <= 4'd0;
            i_q        <= 6'd0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_round_q <= 4'd0;
            rk_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ks_q       <= ks_d;
            key_q      <= key_d;
            win_q      <= win_d;
            asm_q      <= asm_d;
            mod_q      <= mod_d;
            rcon_q     <= rcon_d;
            i_q        <= i_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_round_q <= rk_round_d;
            rk_last_q  <= rk_last_d;
            done_q     <= done_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign rk_valid    = rk_valid_q;
    assign rk_data     = rk_data_q;
    assign rk_round    = rk_round_q;
    assign rk_last     = rk_last_q;
    assign done        = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: an independent FIPS-197 expansion model
// feeds expected round keys; a negedge monitor pops and compares on every handshake.
module tb_aes_key_schedule;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   r;
        logic         l;
    } exp_t;

    logic         CLK = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   key_size = 2'd0;
    logic [255:0] key_in = '0;
    logic         rk_ready = 1'b0;
    logic         start_ready, rk_valid, rk_last, done;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;

    int           n_vec = 0;
    int           n_err = 0;
    int           hs_cnt = 0;
    logic [7:0]   sb [256];
    exp_t         exp_q [$];
    exp_t         e_mon;
    logic [127:0] cap [15];
    logic [127:0] ref_cap [15];
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic [3:0]   prev_round;
    logic         prev_last;

    aes_key_schedule #(.KEY_W(256), .RK_W(128)) dut (
        .CLK         (CLK),
        .rst         (rst),
        .start       (start),
        .start_ready (start_ready),
        .key_size    (key_size),
        .key_in      (key_in),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_round    (rk_round),
        .rk_last     (rk_last),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse plus the affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] y, s;
        y = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(x, 8'(c)) == 8'h01) y = 8'(c);
        end
        s = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic void push_expected(input logic [255:0] k, input logic [1:0] ks);
        int          nk, nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        exp_t        e;
        nk = (ks == 2'd0) ? 4 : (ks == 2'd1) ? 6 : 8;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = k[255 - 32 * i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk == 8 && i % nk == 4) begin
                    t = sub_w(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            e.d = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            e.r = 4'(r);
            e.l = (r == nr);
            exp_q.push_back(e);
        end
    endfunction

    always @(negedge CLK) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (rk_valid !== 1'b1 || rk_data !== prev_data || rk_round !== prev_round || rk_last !== prev_last) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%b round=%0d data=%h, required valid=1 round=%0d data=%h",
                             rk_valid, rk_round, rk_data, prev_round, prev_data);
                end
            end
            if (rk_valid && rk_ready) begin
                hs_cnt++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_key: round=%0d data=%h, required no handshake", rk_round, rk_data);
                end else begin
                    e_mon = exp_q.pop_front();
                    if ({rk_data, rk_round, rk_last} !== {e_mon.d, e_mon.r, e_mon.l}) begin
                        n_err++;
                        $display("FAIL round_key: got r=%0d last=%b %h, required r=%0d last=%b %h",
                                 rk_round, rk_last, rk_data, e_mon.r, e_mon.l, e_mon.d);
                    end
                end
                if (rk_round <= 4'd14) cap[rk_round] = rk_data;
            end
            prev_stall = rk_valid && !rk_ready;
            prev_data  = rk_data;
            prev_round = rk_round;
            prev_last  = rk_last;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input logic [255:0] k, input logic [1:0] ks);
        if (ks != 2'd3) push_expected(k, ks);
        key_in   = k;
        key_size = ks;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Returns at the negedge before the rk_last handshake edge.
    task automatic run_to_last(input bit rnd, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        for (int c = 0; c < 3000 && !found; c++) begin
            tick();
            rk_ready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
            cycles++;
            @(negedge CLK);
            if (rk_valid && rk_ready && rk_last) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout_last: no rk_last handshake within %0d cycles", cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge CLK);
        n_vec++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL reset_start_ready: got %b, required 1", start_ready); end
        n_vec++; if (rk_valid !== 1'b0) begin n_err++; $display("FAIL reset_rk_valid: got %b, required 0", rk_valid); end
        n_vec++; if (rk_data !== 128'h0) begin n_err++; $display("FAIL reset_rk_data: got %h, required 0", rk_data); end
        n_vec++; if (rk_round !== 4'd0) begin n_err++; $display("FAIL reset_rk_round: got %0d, required 0", rk_round); end
        n_vec++; if (rk_last !== 1'b0) begin n_err++; $display("FAIL reset_rk_last: got %b, required 0", rk_last); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", done); end
    endtask

    task automatic test_illegal();
        key_in   = K128;
        key_size = 2'd3;
        start    = 1'b1;
        rk_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            @(negedge CLK);
            n_vec++;
            if (start_ready !== 1'b1 || rk_valid !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL illegal_size: cycle %0d start_ready=%b rk_valid=%b done=%b, required 1/0/0",
                         c, start_ready, rk_valid, done);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_aes128();
        int cyc;
        rk_ready = 1'b1;
        hs_cnt   = 0;
        start_job(K128, 2'd0);
        repeat (3) tick();
        @(negedge CLK);
        n_vec++; if (rk_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: rk_valid=%b 3 cycles after start, required 0", rk_valid); end
        tick();
        @(negedge CLK);
        n_vec++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd0) begin
            n_err++;
            $display("FAIL latency_first: rk_valid=%b round=%0d 4 cycles after start, required 1/0", rk_valid, rk_round);
        end
        run_to_last(1'b0, cyc);
        n_vec++; if (4 + cyc != 44) begin n_err++; $display("FAIL aes128_last_time: round 10 at %0d cycles, required 44", 4 + cyc); end
        tick();
        @(negedge CLK);
        n_vec++;
        if (done !== 1'b1 || start_ready !== 1'b1 || rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL aes128_done: done=%b start_ready=%b rk_valid=%b, required 1/1/0", done, start_ready, rk_valid);
        end
        n_vec++; if (cap[1][127:96] !== 32'ha0fafe17) begin n_err++; $display("FAIL aes128_w4: got %h, required a0fafe17", cap[1][127:96]); end
        n_vec++;
        if (cap[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_err++;
            $display("FAIL aes128_round10: got %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", cap[10]);
        end
        n_vec++; if (hs_cnt != 11) begin n_err++; $display("FAIL aes128_count: got %0d handshakes, required 11", hs_cnt); end
        tick();
        @(negedge CLK);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b, required 0", done); end
        ref_cap = cap;
    endtask

    task automatic test_aes192();
        int cyc;
        rk_ready = 1'b1;
        hs_cnt   = 0;
        start_job(K192, 2'd1);
        run_to_last(1'b0, cyc);
        tick();
        @(negedge CLK);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL aes192_done: got %b, required 1", done); end
        n_vec++; if (cap[1][63:32] !== 32'hfe0c91f7) begin n_err++; $display("FAIL aes192_w6: got %h, required fe0c91f7", cap[1][63:32]); end
        n_vec++;
        if (cap[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
            n_err++;
            $display("FAIL aes192_round12: got %h, required e98ba06f448c773c8ecc720401002202", cap[12]);
        end
        n_vec++; if (hs_cnt != 13) begin n_err++; $display("FAIL aes192_count: got %0d handshakes, required 13", hs_cnt); end
        tick();
    endtask

    task automatic test_aes256();
        int cyc;
        rk_ready = 1'b1;
        hs_cnt   = 0;
        start_job(K256, 2'd2);
        run_to_last(1'b0, cyc);
        tick();
        @(negedge CLK);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL aes256_done: got %b, required 1", done); end
        n_vec++; if (cap[2][127:96] !== 32'h9ba35411) begin n_err++; $display("FAIL aes256_w8: got %h, required 9ba35411", cap[2][127:96]); end
        n_vec++;
        if (cap[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            n_err++;
            $display("FAIL aes256_round14: got %h, required fe4890d1e6188d0b046df344706c631e", cap[14]);
        end
        n_vec++; if (hs_cnt != 15) begin n_err++; $display("FAIL aes256_count: got %0d handshakes, required 15", hs_cnt); end
        tick();
    endtask

    task automatic test_stalls();
        int cyc;
        cap      = '{default: '0};
        rk_ready = 1'b0;
        hs_cnt   = 0;
        start_job(K128, 2'd0);
        run_to_last(1'b1, cyc);
        tick();
        @(negedge CLK);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done: got %b, required 1", done); end
        for (int r = 0; r <= 10; r++) begin
            n_vec++;
            if (cap[r] !== ref_cap[r]) begin
                n_err++;
                $display("FAIL stall_sequence: round %0d got %h, required %h", r, cap[r], ref_cap[r]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        rk_ready = 1'b1;
        hs_cnt   = 0;
        start_job(K192, 2'd1);
        run_to_last(1'b0, cyc);
        tick();
        push_expected(K128, 2'd0);
        key_in   = K128;
        key_size = 2'd0;
        start    = 1'b1;
        @(negedge CLK);
        n_vec++;
        if (done !== 1'b1 || start_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done_cycle: done=%b start_ready=%b, required 1/1", done, start_ready);
        end
        tick();
        start = 1'b0;
        run_to_last(1'b0, cyc);
        n_vec++; if (cyc != 44) begin n_err++; $display("FAIL b2b_timing: last key %0d cycles after start, required 44", cyc); end
        tick();
        @(negedge CLK);
        n_vec++; if (hs_cnt != 24) begin n_err++; $display("FAIL b2b_count: got %0d handshakes, required 24", hs_cnt); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_leftover: %0d keys not produced, required 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_reset_midjob();
        int cyc;
        rk_ready = 1'b1;
        start_job(K256, 2'd2);
        repeat (10) tick();
        key_in   = K128;
        key_size = 2'd0;
        start    = 1'b1;
        @(negedge CLK);
        n_vec++; if (start_ready !== 1'b0) begin n_err++; $display("FAIL busy_start_ready: got %b, required 0", start_ready); end
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        n_vec++;
        if (rk_valid !== 1'b0 || rk_data !== 128'h0 || rk_round !== 4'd0 || rk_last !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL midjob_reset_outputs: valid=%b data=%h round=%0d last=%b done=%b, required all 0",
                     rk_valid, rk_data, rk_round, rk_last, done);
        end
        n_vec++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL midjob_reset_ready: got %b, required 1", start_ready); end
        hs_cnt = 0;
        cap    = '{default: '0};
        start_job(K128, 2'd0);
        run_to_last(1'b0, cyc);
        tick();
        @(negedge CLK);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL midjob_new_done: got %b, required 1", done); end
        n_vec++; if (hs_cnt != 11) begin n_err++; $display("FAIL midjob_new_count: got %0d handshakes, required 11", hs_cnt); end
        n_vec++;
        if (cap[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_err++;
            $display("FAIL midjob_new_round10: got %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", cap[10]);
        end
        tick();
    endtask

    initial begin
        for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
        cap     = '{default: '0};
        ref_cap = '{default: '0};
        test_reset();
        test_illegal();
        test_aes128();
        test_aes192();
        test_aes256();
        test_stalls();
        test_back_to_back();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
